down_counter: RTL and testbench
===============================

# down_counter

Loadable 8-bit down-counter (countdown timer) that complements the existing up-counter. It shares that block's Data/load/enable/Q interface. It counts toward zero instead of away from it, and flags terminal count with a one-cycle pulse. It serves as the interval/timeout source for control logic that consumes the up-counter's values.

## Interface
- WIDTH, 8, counter and data width in bits
- clk  input  1  rising-edge clock; all state updates on posedge clk
- reset  input  1  synchronous, active-low; sampled on posedge clk, clears all state while low
- Data  input  WIDTH  value captured when load is high
- load  input  1  capture Data into Q on next posedge
- enable  input  1  allows one decrement per cycle while RUN
- Q  output  WIDTH  current count
- zero  output  1  level, high whenever Q == 0
- tc  output  1  terminal-count pulse, high for exactly one cycle
- busy  output  1  high while state == RUN

## Operation
- Priority on each posedge: reset low > load > enable.
- The control FSM has three states: IDLE, RUN and DONE.
- **Reset** (reset low): Q = 0, state = IDLE, tc = 0, busy = 0, zero = 1.
- **Load** (load high, any state):
  - Q <= Data; tc <= 0.
  - Next state is RUN if Data != 0, else IDLE.
  - Load is never counted as a decrement, even if enable is also high.
- **RUN**:
  - enable high and Q > 1: Q <= Q - 1.
  - enable high and Q == 1: Q <= 0, tc <= 1, state <= DONE.
  - enable low: Q, state and tc hold; tc stays 0.
- **DONE**:
  - Q holds 0.
  - tc returns to 0 one cycle after assertion.
  - enable is ignored; only load or reset leaves DONE.
- **IDLE**: Q holds; enable is ignored.
- **No wrap-around**: Q never decrements below 0.
- **Derived outputs**: zero = (Q == 0), combinational from the Q register; busy = (state == RUN).

## Timing
- **Load latency**: 1 cycle. Q shows Data at the posedge where load was sampled high.
- **Decrement rate**: one per cycle with enable high. From load of N (N >= 1), enable held high from the next cycle makes Q reach 0 N cycles later.
- **tc timing**:
  - tc is registered and asserted in the same cycle Q first shows 0.
  - Width is exactly 1 cycle, regardless of enable.
- **Load coinciding with terminal count**: load wins. Q <= Data, tc stays 0, and no terminal count is reported for the old run.
- **Reset mid-run**: takes effect at that posedge. Q = 0 and tc = 0 the following cycle; any pending terminal count is discarded.
- **Pause/resume**: dropping enable mid-count freezes Q. Raising it again resumes from the frozen value with no lost or extra steps.

## Configuration
- Macro: DOWN_COUNTER_AUTO_RELOAD_EN.
- **Defined**:
  - A WIDTH-bit reload register captures Data on every load.
  - In RUN, when enable is high and Q == 1: Q <= reload value, tc <= 1, and the state stays RUN.
  - The result is a periodic tc, every N enabled cycles for load value N.
  - DONE is unreachable; Q never shows 0 after a nonzero load.
- **Undefined**: no reload register; one-shot behaviour as described under Operation.
- Reset, load-priority and tc-width rules are identical in both builds.

## Structure
- **Shared package down_counter_pkg** holds:
  - the state enum (IDLE, RUN, DONE);
  - the localparam for the default WIDTH, 8.
- **No sub-module**: the FSM, count register and tc flop belong in one module. The optional reload register sits under the macro guard.

## Test plan
All scenarios use a 10-unit clock period.
- **Reset**: hold reset low for 2 cycles with load = 1 and Data = 0xAA -> Q = 0x00, zero = 1, busy = 0, tc = 0; load is ignored.
- **Countdown**: load 0x05, then enable high -> Q steps 5, 4, 3, 2, 1, 0 on successive cycles; tc is high only in the cycle Q = 0; Q then holds 0 with enable still high.
- **Pause**: load 0x55, enable high for 3 cycles (Q = 0x52), enable low for 2 cycles -> Q stays 0x52; re-enable -> next Q = 0x51.
- **Load/enable collision**: load 0x03 with enable high in the same cycle -> Q = 0x03 (no decrement); load 0x00 -> Q = 0, state IDLE, tc never asserts.
- **Load at terminal count and reset mid-run**:
  - With Q = 1 and enable high, assert load with Data = 0xFF -> Q = 0xFF, tc = 0.
  - Then pull reset low mid-run -> Q = 0 next cycle.
- **Auto-reload** (DOWN_COUNTER_AUTO_RELOAD_EN defined only): load 0x03, enable held high -> Q sequence 3, 2, 1, 3, 2, 1, ...; tc pulses each cycle Q reloads to 3; busy stays 1.

Source files
------------

// File: rtl/down_counter_pkg.sv
// Shared definitions for the loadable down-counter: control states and default width.
package down_counter_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/down_counter.sv
// Loadable down-counter with one-cycle terminal-count pulse.
// Optional macro DOWN_COUNTER_AUTO_RELOAD_EN turns the one-shot into a periodic timer.
module down_counter
    import down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] Data,
    input  logic             load,
    input  logic             enable,
    output logic [WIDTH-1:0] Q,
    output logic             zero,
    output logic             tc,
    output logic             busy
);

    state_t           state, state_n;
    logic [WIDTH-1:0] q_n;
    logic             tc_n;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload, reload_n;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            Q     <= '0;
            tc    <= 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            reload <= '0;
`endif
        end else begin
            state <= state_n;
            Q     <= q_n;
            tc    <= tc_n;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            reload <= reload_n;
`endif
        end
    end

    // tc defaults low every cycle, which bounds the pulse to exactly one cycle.
    always_comb begin
        state_n = state;
        q_n     = Q;
        tc_n    = 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        reload_n = reload;
`endif
        if (load) begin
            q_n     = Data;
            state_n = (Data != '0) ? RUN : IDLE;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            reload_n = Data;
`endif
        end else begin
            case (state)
                RUN: begin
                    if (enable) begin
                        if (Q > WIDTH'(1)) begin
                            q_n = Q - WIDTH'(1);
                        end else begin
                            tc_n = 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                            q_n = reload;
`else
                            q_n     = '0;
                            state_n = DONE;
`endif
                        end
                    end
                end
                DONE: begin
                    q_n = '0;
                end
                default: begin
                    state_n = state;
                end
            endcase
        end
    end

    assign zero = (Q == '0);
    assign busy = (state == RUN);

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: vector table plus hand-written corner sequences.
module tb_down_counter;

    logic       clk;
    logic       reset;
    logic [7:0] Data;
    logic       load;
    logic       enable;
    logic [7:0] Q;
    logic       zero;
    logic       tc;
    logic       busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      name;
        logic       rst_n;
        logic       ld;
        logic [7:0] d;
        logic       en;
        logic [7:0] q;
        logic       tc;
        logic       busy;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    down_counter #(.WIDTH(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .Data   (Data),
        .load   (load),
        .enable (enable),
        .Q      (Q),
        .zero   (zero),
        .tc     (tc),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (got running, want finished)");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic rst_n, input logic ld,
                                input logic [7:0] d, input logic en, input logic [7:0] q,
                                input logic t, input logic b);
        vec_t v;
        v.name = name; v.rst_n = rst_n; v.ld = ld; v.d = d; v.en = en;
        v.q = q; v.tc = t; v.busy = b;
        return v;
    endfunction

    // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
    task automatic step(input vec_t v);
        vec_t e;
        reset  = v.rst_n;
        load   = v.ld;
        Data   = v.d;
        enable = v.en;
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL %s: scoreboard empty (got 0 entries, want 1)", v.name);
        end else begin
            e = sb.pop_front();
            chk({e.name, ".Q"},    int'(Q),    int'(e.q));
            chk({e.name, ".zero"}, int'(zero), int'(e.q == 8'h00));
            chk({e.name, ".tc"},   int'(tc),   int'(e.tc));
            chk({e.name, ".busy"}, int'(busy), int'(e.busy));
        end
    endtask

    initial begin
        reset = 1'b0; load = 1'b0; Data = 8'h00; enable = 1'b0;

        // Reset dominates a simultaneous load.
        vecs.push_back(mk("rst0", 0, 1, 8'hAA, 0, 8'h00, 0, 0));
        vecs.push_back(mk("rst1", 0, 1, 8'hAA, 0, 8'h00, 0, 0));
        vecs.push_back(mk("idle_en", 1, 0, 8'h00, 1, 8'h00, 0, 0));
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        vecs.push_back(mk("ar_ld3", 1, 1, 8'h03, 0, 8'h03, 0, 1));
        vecs.push_back(mk("ar_2a",  1, 0, 8'h00, 1, 8'h02, 0, 1));
        vecs.push_back(mk("ar_1a",  1, 0, 8'h00, 1, 8'h01, 0, 1));
        vecs.push_back(mk("ar_3a",  1, 0, 8'h00, 1, 8'h03, 1, 1));
        vecs.push_back(mk("ar_2b",  1, 0, 8'h00, 1, 8'h02, 0, 1));
        vecs.push_back(mk("ar_1b",  1, 0, 8'h00, 1, 8'h01, 0, 1));
        vecs.push_back(mk("ar_3b",  1, 0, 8'h00, 1, 8'h03, 1, 1));
        vecs.push_back(mk("ar_2c",  1, 0, 8'h00, 0, 8'h03, 0, 1));
`else
        vecs.push_back(mk("cd_ld5", 1, 1, 8'h05, 0, 8'h05, 0, 1));
        vecs.push_back(mk("cd_4",   1, 0, 8'h00, 1, 8'h04, 0, 1));
        vecs.push_back(mk("cd_3",   1, 0, 8'h00, 1, 8'h03, 0, 1));
        vecs.push_back(mk("cd_2",   1, 0, 8'h00, 1, 8'h02, 0, 1));
        vecs.push_back(mk("cd_1",   1, 0, 8'h00, 1, 8'h01, 0, 1));
        vecs.push_back(mk("cd_0",   1, 0, 8'h00, 1, 8'h00, 1, 0));
        vecs.push_back(mk("cd_hold0", 1, 0, 8'h00, 1, 8'h00, 0, 0));
        vecs.push_back(mk("cd_hold1", 1, 0, 8'h00, 1, 8'h00, 0, 0));
`endif
        // Load beats enable; loading zero goes idle without a terminal count.
        vecs.push_back(mk("col_ld3", 1, 1, 8'h03, 1, 8'h03, 0, 1));
        vecs.push_back(mk("col_ld0", 1, 1, 8'h00, 1, 8'h00, 0, 0));
        vecs.push_back(mk("col_idle", 1, 0, 8'h00, 1, 8'h00, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i]);
        end

        // Pause and resume.
        step(mk("pz_ld55", 1, 1, 8'h55, 0, 8'h55, 0, 1));
        step(mk("pz_54",   1, 0, 8'h00, 1, 8'h54, 0, 1));
        step(mk("pz_53",   1, 0, 8'h00, 1, 8'h53, 0, 1));
        step(mk("pz_52",   1, 0, 8'h00, 1, 8'h52, 0, 1));
        step(mk("pz_hold", 1, 0, 8'h00, 0, 8'h52, 0, 1));
        step(mk("pz_hold", 1, 0, 8'h00, 0, 8'h52, 0, 1));
        step(mk("pz_51",   1, 0, 8'h00, 1, 8'h51, 0, 1));

        // Load at terminal count, then reset mid-run.
        step(mk("tc_ld2",  1, 1, 8'h02, 0, 8'h02, 0, 1));
        step(mk("tc_1",    1, 0, 8'h00, 1, 8'h01, 0, 1));
        step(mk("tc_ldff", 1, 1, 8'hFF, 1, 8'hFF, 0, 1));
        step(mk("tc_fe",   1, 0, 8'h00, 1, 8'hFE, 0, 1));
        step(mk("mid_rst", 0, 0, 8'h00, 1, 8'h00, 0, 0));
        step(mk("post_rst", 1, 0, 8'h00, 1, 8'h00, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
